// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle adder/subtractor. Operands are consumed BITS_PER_CYCLE bits per
//   clock, LSB slice first. One registered carry links the slices. Subtraction
//   is a + ~b + 1: b is inverted and the carry is preset to 1 when the operands
//   are captured.
//
//   A request is taken when start is high in IDLE or DONE. The unit then spends
//   N = WIDTH/BITS_PER_CYCLE cycles in RUN (busy=1) and one cycle in DONE
//   (done=1). A start seen during DONE is accepted back-to-back.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request, sampled in IDLE/DONE only
//   sub        in   1      0 = a+b, 1 = a-b (sampled with start)
//   a, b       in   WIDTH  operands (sampled with start)
//   busy       out  1      high while the operation runs
//   done       out  1      one-cycle result-valid pulse
//   sum        out  WIDTH  result, held from done until the next accepted start
//   carry_out  out  1      carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Refuse to elaborate with a width the slicing cannot cover exactly.
  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [BPC:0]       w_slice;
  logic               w_msb_cin;
  logic [WIDTH-1:0]   w_slice_ext;

  // A start is only considered when no operation is in flight.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  // The operand registers shift right each cycle, so the slice being worked on
  // is always at the bottom.
  assign w_slice = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + (BPC + 1)'(r_carry);

  // Carry into the top bit of the slice, recovered from that bit's own sum:
  // s = a ^ b ^ cin, so cin = a ^ b ^ s. On the final slice this is the carry
  // into the operand MSB, and it works for any slice width, including 1.
  assign w_msb_cin = r_a[BPC-1] ^ r_b[BPC-1] ^ w_slice[BPC-1];

  // New slice result enters at the top of the sum register. After N shifts the
  // first (LSB) slice has moved down to bit 0.
  assign w_slice_ext = WIDTH'(w_slice[BPC-1:0]) << (WIDTH - BPC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment comes first, so every path through the case
  // drives w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the operand, carry and counter registers are flops, not a memory
  // array, so they are cleared by reset along with the visible outputs. An
  // abandoned operation therefore leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> BPC;
      r_b     <= r_b >> BPC;
      r_sum   <= (r_sum >> BPC) | w_slice_ext;
      r_carry <= w_slice[BPC];
      // Only the value from the final slice is meaningful; earlier ones are
      // overwritten before done.
      r_ovf   <= w_msb_cin ^ w_slice[BPC];
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

endmodule
